// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } rf_entry_t;

  // Register 0 is hardwired, so it never counts as a match.
  function automatic logic entry_hit(input rf_entry_t e, input logic [REG_ADDR_W-1:0] a);
    return e.valid && (a != REG_ZERO) && (e.addr == a);
  endfunction

endpackage

// File: rtl/rf_arb_queue.sv
// Compacting oldest-first queue of deferred multicycle results with
// push, pop-oldest, squash-by-address and per-entry source matching.
module rf_arb_queue
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [REG_ADDR_W-1:0]        push_addr,
  input  logic [REG_DATA_W-1:0]        push_data,
  input  logic                         pop,
  input  logic                         squash,
  input  logic [REG_ADDR_W-1:0]        squash_addr,
  input  logic [REG_ADDR_W-1:0]        match_addr1,
  input  logic [REG_ADDR_W-1:0]        match_addr2,
  output rf_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [DEPTH-1:0]             match1,
  output logic [DEPTH-1:0]             match2
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rf_entry_t          entry_q [DEPTH];
  rf_entry_t          entry_d [DEPTH];
  logic [OCC_W-1:0]   wr;

  // Survivors are copied down in order, then the new result lands at the tail.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_d[i] = '0;
    end
    wr = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entry_q[i].valid && !(pop && (i == 0)) &&
          !(squash && (entry_q[i].addr == squash_addr))) begin
        entry_d[wr[IDX_W-1:0]] = entry_q[i];
        wr = wr + OCC_W'(1);
      end
    end
    if (push && (wr < OCC_W'(DEPTH))) begin
      entry_d[wr[IDX_W-1:0]].valid = 1'b1;
      entry_d[wr[IDX_W-1:0]].addr  = push_addr;
      entry_d[wr[IDX_W-1:0]].data  = push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    match1    = '0;
    match2    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occupancy = occupancy + OCC_W'(entry_q[i].valid);
      match1[i] = entry_hit(entry_q[i], match_addr1);
      match2[i] = entry_hit(entry_q[i], match_addr2);
    end
  end

  assign head = entry_q[0];

endmodule

// File: rtl/rf_write_arbiter.sv
// Single write port arbiter: WB always wins, deferred mult/div results drain
// from a small queue, with read-hazard detection and WB starvation relief.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [REG_DATA_W-1:0] wb_data,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_addr,
  input  logic [REG_DATA_W-1:0] md_data,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic                  hazard,
  output logic                  wb_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [REG_DATA_W-1:0] rf_wdata
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic             wb_eff;
  logic             q_empty;
  logic             pop;
  logic             push;
  rf_entry_t        head;
  logic [OCC_W-1:0] occupancy;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             stall_q, stall_d;

  assign wb_eff   = wb_we && (wb_addr != REG_ZERO);
  assign q_empty  = (occupancy == '0);
  assign md_ready = (occupancy < OCC_W'(DEPTH));
  assign pop      = !wb_eff && !q_empty;
  // Writes to register 0 are handshaken but have nowhere to go.
  assign push     = md_valid && md_ready && (md_addr != REG_ZERO);

  rf_arb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_addr   (md_addr),
    .push_data   (md_data),
    .pop         (pop),
    .squash      (wb_eff),
    .squash_addr (wb_addr),
    .match_addr1 (rd_addr1),
    .match_addr2 (rd_addr2),
    .head        (head),
    .occupancy   (occupancy),
    .match1      (match1),
    .match2      (match2)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = REG_ZERO;
    rf_wdata = '0;
    if (reset) begin
      if (wb_eff) begin
        rf_we    = 1'b1;
        rf_waddr = wb_addr;
        rf_wdata = wb_data;
      end else if (!q_empty) begin
        rf_we    = 1'b1;
        rf_waddr = head.addr;
        rf_wdata = head.data;
      end
    end
  end

  assign hazard = (|match1) || (|match2);

  // A non-empty queue is either popping or blocked by WB, never idle.
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (q_empty || pop) begin
      starve_d = '0;
    end else if (wb_eff) begin
      if (starve_q == CNT_W'(STARVE_LIMIT - 1)) begin
        starve_d = '0;
        stall_d  = 1'b1;
      end else begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign wb_stall = stall_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rf_write_arbiter;

  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        hazard;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  rf_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .md_valid (md_valid),
    .md_addr  (md_addr),
    .md_data  (md_data),
    .md_ready (md_ready),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .hazard   (hazard),
    .wb_stall (wb_stall),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] r1, input logic [4:0] r2);
    wb_we = we; wb_addr = wa; wb_data = wd;
    md_valid = mv; md_addr = ma; md_data = md;
    rd_addr1 = r1; rd_addr2 = r2;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd8, 32'h1234, 1'b1, 5'd3, 32'h1, 5'd3, 5'd0);
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL reset_md_ready: got %b want 1", md_ready); end
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    n_tests++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_wb_stall: got %b want 0", wb_stall); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_wb_priority();
    drive(1'b1, 5'd8, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL wb_rf_we: got %b want 1", rf_we); end
    n_tests++; if (rf_waddr !== 5'd8) begin n_fail++; $display("FAIL wb_waddr: got %0d want 8", rf_waddr); end
    n_tests++; if (rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL wb_wdata: got %h want 1234", rf_wdata); end
    n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL wb_md_ready: got %b want 1", md_ready); end
    next_cycle();
  endtask

  task automatic test_md_path();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hCAFE, 5'd0, 5'd0);
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL md_no_fallthrough: got %b want 0", rf_we); end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL md_rf_we: got %b want 1", rf_we); end
    n_tests++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL md_waddr: got %0d want 5", rf_waddr); end
    n_tests++; if (rf_wdata !== 32'hCAFE) begin n_fail++; $display("FAIL md_wdata: got %h want cafe", rf_wdata); end
    n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL md_hazard: got %b want 1", hazard); end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL md_drained: got %b want 0", rf_we); end
    next_cycle();
  endtask

  task automatic test_fill_starve();
    drive(1'b1, 5'd20, 32'h100, 1'b1, 5'd3, 32'h333, 5'd0, 5'd0);
    n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready0: got %b want 1", md_ready); end
    next_cycle();
    drive(1'b1, 5'd21, 32'h101, 1'b1, 5'd4, 32'h444, 5'd4, 5'd0);
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL fill_hazard_early: got %b want 0", hazard); end
    next_cycle();
    drive(1'b1, 5'd22, 32'h102, 1'b0, 5'd0, 32'h0, 5'd4, 5'd0);
    n_tests++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b want 0", md_ready); end
    n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL fill_hazard4: got %b want 1", hazard); end
    n_tests++; if (rf_waddr !== 5'd22) begin n_fail++; $display("FAIL fill_wb_wins: got %0d want 22", rf_waddr); end
    rd_addr1 = 5'd0;
    #1;
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL fill_hazard0: got %b want 0", hazard); end
    next_cycle();
    drive(1'b1, 5'd23, 32'h103, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    n_tests++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_early3: got %b want 0", wb_stall); end
    next_cycle();
    drive(1'b1, 5'd24, 32'h104, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    n_tests++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_early4: got %b want 0", wb_stall); end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    n_tests++; if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL starve_pulse: got %b want 1", wb_stall); end
    n_tests++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL pop_full_ready: got %b want 0", md_ready); end
    n_tests++; if (rf_waddr !== 5'd3) begin n_fail++; $display("FAIL drain_first_addr: got %0d want 3", rf_waddr); end
    n_tests++; if (rf_wdata !== 32'h333) begin n_fail++; $display("FAIL drain_first_data: got %h want 333", rf_wdata); end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd0);
    n_tests++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_one_cycle: got %b want 0", wb_stall); end
    n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_pop: got %b want 1", md_ready); end
    n_tests++; if (rf_waddr !== 5'd4) begin n_fail++; $display("FAIL drain_second_addr: got %0d want 4", rf_waddr); end
    n_tests++; if (rf_wdata !== 32'h444) begin n_fail++; $display("FAIL drain_second_data: got %h want 444", rf_wdata); end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd0);
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL drain_done: got %b want 0", rf_we); end
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL drain_hazard: got %b want 0", hazard); end
    next_cycle();
  endtask

  task automatic test_squash();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h999, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 5'd9, 32'h5555, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL squash_hazard_before: got %b want 1", hazard); end
    n_tests++; if (rf_wdata !== 32'h5555) begin n_fail++; $display("FAIL squash_wb_data: got %h want 5555", rf_wdata); end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9);
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL squash_hazard_after: got %b want 0", hazard); end
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL squash_no_write: got %b want 0", rf_we); end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL squash_no_late_write: got %b want 0", rf_we); end
    next_cycle();
  endtask

  task automatic test_md_zero();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd0);
    n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", md_ready); end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_no_write: got %b want 0", rf_we); end
    n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL zero_occupancy: got %b want 1", md_ready); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd20, 32'h1, 1'b1, 5'd11, 32'hB0B, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 5'd21, 32'h2, 1'b1, 5'd12, 32'hC0C, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 5'd22, 32'h3, 1'b0, 5'd0, 32'h0, 5'd11, 5'd12);
    n_tests++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b want 0", md_ready); end
    #1 reset = 1'b0;
    #1;
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_rf_we: got %b want 0", rf_we); end
    n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL mid_md_ready: got %b want 1", md_ready); end
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL mid_hazard: got %b want 0", hazard); end
    #1 reset = 1'b1;
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd12);
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_discarded: got %b want 0", rf_we); end
    next_cycle();
  endtask

  // Reference model: an ordered list of pending results plus a blocked-cycle count.
  logic [4:0]  m_addr[$];
  logic [31:0] m_data[$];
  int          m_blocked;
  logic        m_stall;

  function automatic logic m_pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (m_addr[k]) if (m_addr[k] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_random();
    logic        we, mv, eff, acc, nonempty, popped;
    logic [4:0]  wa, ma, r1, r2, e_addr;
    logic [31:0] wd, md, e_data;
    logic        e_we;
    logic [4:0]  keep_a[$];
    logic [31:0] keep_d[$];
    m_addr.delete(); m_data.delete(); m_blocked = 0; m_stall = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    reset = 1'b0;
    #2 reset = 1'b1;
    next_cycle();
    for (int cyc = 0; cyc < 600; cyc++) begin
      we = ($urandom_range(0, 9) < 7) && !m_stall;
      wa = 5'($urandom_range(0, 7));
      wd = $urandom;
      mv = 1'($urandom_range(0, 1));
      ma = 5'($urandom_range(0, 7));
      md = $urandom;
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      drive(we, wa, wd, mv, ma, md, r1, r2);
      eff = we && (wa != 5'd0);
      if (eff) begin
        e_we = 1'b1; e_addr = wa; e_data = wd;
      end else if (m_addr.size() > 0) begin
        e_we = 1'b1; e_addr = m_addr[0]; e_data = m_data[0];
      end else begin
        e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0;
      end
      n_tests++; if (rf_we !== e_we) begin n_fail++; $display("FAIL rnd_rf_we cyc %0d: got %b want %b", cyc, rf_we, e_we); end
      n_tests++; if (rf_waddr !== e_addr) begin n_fail++; $display("FAIL rnd_waddr cyc %0d: got %0d want %0d", cyc, rf_waddr, e_addr); end
      n_tests++; if (rf_wdata !== e_data) begin n_fail++; $display("FAIL rnd_wdata cyc %0d: got %h want %h", cyc, rf_wdata, e_data); end
      n_tests++; if (md_ready !== (m_addr.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_md_ready cyc %0d: got %b want %b", cyc, md_ready, m_addr.size() < DEPTH); end
      n_tests++; if (hazard !== (m_pending(r1) || m_pending(r2))) begin n_fail++; $display("FAIL rnd_hazard cyc %0d: got %b want %b", cyc, hazard, m_pending(r1) || m_pending(r2)); end
      n_tests++; if (wb_stall !== m_stall) begin n_fail++; $display("FAIL rnd_wb_stall cyc %0d: got %b want %b", cyc, wb_stall, m_stall); end
      acc      = mv && (m_addr.size() < DEPTH);
      nonempty = m_addr.size() > 0;
      popped   = 1'b0;
      if (eff) begin
        keep_a.delete(); keep_d.delete();
        foreach (m_addr[k]) if (m_addr[k] != wa) begin keep_a.push_back(m_addr[k]); keep_d.push_back(m_data[k]); end
        m_addr = keep_a; m_data = keep_d;
      end else if (nonempty) begin
        void'(m_addr.pop_front()); void'(m_data.pop_front());
        popped = 1'b1;
      end
      if (!nonempty || popped) begin
        m_blocked = 0; m_stall = 1'b0;
      end else begin
        m_blocked++;
        m_stall = (m_blocked == STARVE_LIMIT);
        if (m_stall) m_blocked = 0;
      end
      if (acc && (ma != 5'd0)) begin
        m_addr.push_back(ma); m_data.push_back(md);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_wb_priority();
    test_md_path();
    test_fill_starve();
    test_squash();
    test_md_zero();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
